// File: rtl/pcw_pkg.sv
// Shared types and defaults for the pixel/CPU video memory arbiter.
package pcw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VID    = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } arb_state_e;

    localparam int unsigned STARVE_MAX_DEF = 3;

    function automatic logic is_cpu_state(input arb_state_e st);
        return (st == CPU_RD) || (st == CPU_WR);
    endfunction

endpackage

// File: rtl/video_mem_arbiter.sv
// Shares one synchronous-read RAM between a strobed video fetcher and a level-handshake CPU port.
// state_q owns the current address cycle; phase_q owns the overlapping data phase.
module video_mem_arbiter
    import pcw_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned AW         = 17
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [7:0]    vid_data,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_wait,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] StarveLim = SW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    arb_state_e    phase_q;
    logic          vid_pend_q, vid_pend_d;
    logic [AW-1:0] vid_addr_q, vid_addr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic [7:0]    vid_data_q;
    logic [7:0]    cpu_rdata_q;

    logic          vid_any;
    logic [AW-1:0] vid_cur_addr;
    logic          cpu_elig;
    logic          vid_strobe;
    logic          cpu_strobe;
    logic          rd_strobe;

    // A fresh strobe counts as pending this cycle and overrides any older address.
    always_comb begin
        vid_any      = vid_pend_q | vid_req;
        vid_cur_addr = vid_req ? vid_addr : vid_addr_q;
        // The CPU is not eligible again until the cycle after its ack.
        cpu_elig     = cpu_req & ~is_cpu_state(state_q) & ~is_cpu_state(phase_q);
    end

    always_comb begin
        state_d = IDLE;
        if (vid_any && (starve_q < StarveLim)) begin
            state_d = VID;
        end else if (cpu_elig) begin
            state_d = cpu_we ? CPU_WR : CPU_RD;
        end else if (vid_any) begin
            state_d = VID;
        end
    end

    always_comb begin
        ram_addr_d  = '0;
        ram_we_d    = 1'b0;
        ram_wdata_d = '0;
        case (state_d)
            VID: begin
                ram_addr_d = vid_cur_addr;
            end
            CPU_RD: begin
                ram_addr_d = cpu_addr;
            end
            CPU_WR: begin
                ram_addr_d  = cpu_addr;
                ram_we_d    = 1'b1;
                ram_wdata_d = cpu_wdata;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        vid_pend_d = vid_any & (state_d != VID);
        vid_addr_d = vid_cur_addr;

        if (!cpu_req || is_cpu_state(state_d)) begin
            starve_d = '0;
        end else if ((state_d == VID) && (starve_q < StarveLim)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Data-phase strobes are gated by reset so an interrupted access never completes.
    always_comb begin
        vid_strobe = (phase_q == VID) & ~reset;
        cpu_strobe = is_cpu_state(phase_q) & ~reset;
        rd_strobe  = (phase_q == CPU_RD) & ~reset;

        vid_valid  = vid_strobe;
        vid_data   = vid_strobe ? ram_rdata : vid_data_q;
        cpu_ack    = cpu_strobe;
        cpu_rdata  = rd_strobe ? ram_rdata : cpu_rdata_q;
        cpu_wait   = cpu_req & ~cpu_strobe;

        ram_addr   = ram_addr_q;
        ram_we     = ram_we_q & ~reset;
        ram_wdata  = ram_wdata_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= IDLE;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            starve_q    <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_data_q  <= 8'h00;
            cpu_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_q     <= state_q;
            vid_pend_q  <= vid_pend_d;
            vid_addr_q  <= vid_addr_d;
            starve_q    <= starve_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_data_q  <= vid_data;
            cpu_rdata_q <= cpu_rdata;
        end
    end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_video_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [16:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:131071];
    logic        pre_we;
    logic [16:0] pre_addr;
    logic [7:0]  pre_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] exp_addr [0:5];
    logic [31:0] exp_wait [0:5];
    logic [31:0] exp_ack  [0:5];
    logic [31:0] exp_vv   [0:5];
    logic [31:0] exp_vd   [0:5];

    always #5 clk_sys = ~clk_sys;

    video_mem_arbiter dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_wait  (cpu_wait),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk_sys) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_sys);
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        vid_req   = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        preload(17'h00010, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            preload(17'(17'h00100 + i), 8'(8'h10 + i));
        end
        preload(17'h00200, 8'h5A);
        preload(17'h00300, 8'h11);

        // Reset values.
        settle();
        check("rst_vid_valid", 32'(vid_valid), 'h0);
        check("rst_cpu_ack",   32'(cpu_ack),   'h0);
        check("rst_ram_we",    32'(ram_we),    'h0);
        check("rst_ram_addr",  32'(ram_addr),  'h0);
        check("rst_vid_data",  32'(vid_data),  'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 'h0);
        tick();
        reset = 1'b0;
        settle();
        check("idle_ram_addr", 32'(ram_addr), 'h0);

        // Single video fetch: valid two cycles after the strobe.
        tick();
        vid_req  = 1'b1;
        vid_addr = 17'h00010;
        settle();
        check("v_c0_addr", 32'(ram_addr), 'h0);
        tick();
        vid_req = 1'b0;
        settle();
        check("v_c1_addr",  32'(ram_addr),  'h10);
        check("v_c1_we",    32'(ram_we),    'h0);
        check("v_c1_valid", 32'(vid_valid), 'h0);
        tick();
        settle();
        check("v_c2_valid", 32'(vid_valid), 'h1);
        check("v_c2_data",  32'(vid_data),  'hA5);
        tick();
        settle();
        check("v_c3_valid", 32'(vid_valid), 'h0);
        check("v_c3_hold",  32'(vid_data),  'hA5);
        check("v_c3_addr",  32'(ram_addr),  'h0);

        // CPU write then read-back.
        tick();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'h1F000;
        cpu_wdata = 8'h3C;
        settle();
        check("w_c0_wait", 32'(cpu_wait), 'h1);
        check("w_c0_we",   32'(ram_we),   'h0);
        tick();
        settle();
        check("w_c1_we",    32'(ram_we),    'h1);
        check("w_c1_addr",  32'(ram_addr),  'h1F000);
        check("w_c1_wdata", 32'(ram_wdata), 'h3C);
        check("w_c1_ack",   32'(cpu_ack),   'h0);
        tick();
        settle();
        check("w_c2_we",   32'(ram_we),   'h0);
        check("w_c2_ack",  32'(cpu_ack),  'h1);
        check("w_c2_wait", 32'(cpu_wait), 'h0);
        tick();
        cpu_we = 1'b0;
        settle();
        check("r_c0_ack", 32'(cpu_ack), 'h0);
        check("r_c0_we",  32'(ram_we),  'h0);
        tick();
        settle();
        check("r_c1_addr", 32'(ram_addr), 'h1F000);
        check("r_c1_we",   32'(ram_we),   'h0);
        tick();
        settle();
        check("r_c2_ack",   32'(cpu_ack),   'h1);
        check("r_c2_rdata", 32'(cpu_rdata), 'h3C);
        tick();
        cpu_req = 1'b0;
        settle();
        check("r_c3_ack",  32'(cpu_ack),   'h0);
        check("r_c3_hold", 32'(cpu_rdata), 'h3C);
        check("r_c3_wait", 32'(cpu_wait),  'h0);

        // Video strobing every cycle against a held CPU read: three video grants, then CPU.
        exp_addr = '{'h0, 'h100, 'h101, 'h102, 'h200, 'h104};
        exp_wait = '{'h1, 'h1, 'h1, 'h1, 'h1, 'h0};
        exp_ack  = '{'h0, 'h0, 'h0, 'h0, 'h0, 'h1};
        exp_vv   = '{'h0, 'h0, 'h1, 'h1, 'h1, 'h0};
        exp_vd   = '{'hA5, 'hA5, 'h10, 'h11, 'h12, 'h12};
        for (int i = 0; i < 6; i++) begin
            tick();
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            cpu_addr = 17'h00200;
            vid_req  = 1'b1;
            vid_addr = 17'(17'h00100 + i);
            settle();
            check("s_addr",  32'(ram_addr),  exp_addr[i]);
            check("s_wait",  32'(cpu_wait),  exp_wait[i]);
            check("s_ack",   32'(cpu_ack),   exp_ack[i]);
            check("s_valid", 32'(vid_valid), exp_vv[i]);
            check("s_vdata", 32'(vid_data),  exp_vd[i]);
        end
        check("s_rdata", 32'(cpu_rdata), 'h5A);
        tick();
        cpu_req = 1'b0;
        vid_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end

        // Simultaneous video and CPU requests from idle.
        tick();
        vid_req  = 1'b1;
        vid_addr = 17'h00010;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 17'h1F000;
        settle();
        check("b_c0_addr", 32'(ram_addr), 'h0);
        tick();
        vid_req = 1'b0;
        settle();
        check("b_c1_addr", 32'(ram_addr), 'h10);
        tick();
        settle();
        check("b_c2_addr",  32'(ram_addr),  'h1F000);
        check("b_c2_valid", 32'(vid_valid), 'h1);
        check("b_c2_vdata", 32'(vid_data),  'hA5);
        check("b_c2_ack",   32'(cpu_ack),   'h0);
        tick();
        settle();
        check("b_c3_ack",   32'(cpu_ack),   'h1);
        check("b_c3_rdata", 32'(cpu_rdata), 'h3C);
        check("b_c3_valid", 32'(vid_valid), 'h0);
        tick();
        cpu_req = 1'b0;

        // Reset landing on the write cycle suppresses the write and its ack.
        tick();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'h00300;
        cpu_wdata = 8'h77;
        settle();
        check("x_c0_we", 32'(ram_we), 'h0);
        tick();
        reset = 1'b1;
        settle();
        check("x_c1_we",  32'(ram_we),  'h0);
        check("x_c1_ack", 32'(cpu_ack), 'h0);
        tick();
        reset   = 1'b0;
        cpu_req = 1'b0;
        settle();
        check("x_c2_valid", 32'(vid_valid), 'h0);
        check("x_c2_ack",   32'(cpu_ack),   'h0);
        check("x_c2_we",    32'(ram_we),    'h0);
        check("x_c2_addr",  32'(ram_addr),  'h0);
        check("x_c2_vdata", 32'(vid_data),  'h0);
        check("x_c2_rdata", 32'(cpu_rdata), 'h0);
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 17'h00300;
        settle();
        check("x_c3_ack", 32'(cpu_ack), 'h0);
        tick();
        settle();
        check("x_c4_addr", 32'(ram_addr), 'h300);
        tick();
        settle();
        check("x_c5_ack",   32'(cpu_ack),   'h1);
        check("x_c5_rdata", 32'(cpu_rdata), 'h11);
        tick();
        cpu_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_mem_arbiter.md
VIDEO_MEM_ARBITER -- requirements
Module: video_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning max consecutive video grants while a CPU request waits.
REQ-002 SHALL have parameter AW, default 17, meaning RAM address width.
REQ-003 SHALL have clk_sys  input  1  64 MHz system clock, the only clock.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have vid_req  input  1  video fetch request, single-cycle strobe.
REQ-006 SHALL have vid_addr  input  AW  video fetch address.
REQ-007 SHALL have vid_valid  output  1  one-cycle strobe when vid_data holds the requested byte.
REQ-008 SHALL have vid_data  output  8  video read data.
REQ-009 SHALL have cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-010 SHALL have cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-011 SHALL have cpu_addr  input  AW  CPU address; stable while cpu_req is high.
REQ-012 SHALL have cpu_wdata  input  8  CPU write data.
REQ-013 SHALL have cpu_ack  output  1  one-cycle completion strobe.
REQ-014 SHALL have cpu_rdata  output  8  CPU read data, valid with cpu_ack.
REQ-015 SHALL have cpu_wait  output  1  high while cpu_req is pending and not yet acknowledged.
REQ-016 SHALL have ram_addr  output  AW  shared RAM address.
REQ-017 SHALL have ram_we  output  1  RAM write strobe.
REQ-018 SHALL have ram_wdata  output  8  RAM write data.
REQ-019 SHALL have ram_rdata  input  8  RAM read data, one-cycle synchronous read latency.

Function
REQ-020 SHALL use states IDLE, VID, CPU_RD, CPU_WR; each access occupies the RAM for exactly one address cycle, followed by a one-cycle data phase.
REQ-021 SHALL latch a vid_req strobe into a one-deep pending flag; a second vid_req while the flag is set SHALL overwrite the address, and the older fetch is dropped.
REQ-022 SHALL, in IDLE or at the end of any data phase, grant video if video is pending and starve_cnt < STARVE_MAX, else CPU if cpu_req is high, else video if pending, else remain in IDLE.
REQ-023 SHALL increment starve_cnt on each video grant made while cpu_req is high, saturating at STARVE_MAX, and clear it on every CPU grant or whenever cpu_req is low.
REQ-024 SHALL, in VID, drive ram_addr = latched video address with ram_we = 0; one cycle later it SHALL set vid_data = ram_rdata and pulse vid_valid.
REQ-025 SHALL, in CPU_RD, drive ram_addr = cpu_addr with ram_we = 0; one cycle later it SHALL set cpu_rdata = ram_rdata and pulse cpu_ack.
REQ-026 SHALL, in CPU_WR, drive ram_addr = cpu_addr, ram_wdata = cpu_wdata and ram_we = 1 for exactly one cycle, then pulse cpu_ack in the following cycle.
REQ-027 SHALL overlap grants back to back: the next grant's address cycle coincides with the previous grant's data phase, giving one access per clock at full load.
REQ-028 SHALL not re-grant the CPU in the cycle cpu_ack is high; the CPU deasserting or re-asserting cpu_req is sampled from the following cycle.
REQ-029 SHALL set cpu_wait = cpu_req & ~cpu_ack, combinationally.
REQ-030 SHALL hold ram_addr at 0 and ram_we at 0 in IDLE.
REQ-031 SHALL keep vid_data and cpu_rdata at their last values between strobes.
REQ-032 SHALL accept a vid_req arriving in the same cycle as cpu_req, with arbitration per REQ-022; with starve_cnt = 0, video wins.
REQ-033 SHALL wrap no address: addresses pass through unmodified at AW bits.

Reset
REQ-034 SHALL, on reset, go to IDLE, clear the video-pending flag and starve_cnt, and drive vid_valid, cpu_ack, ram_we and ram_addr to 0, vid_data and cpu_rdata to 8'h00.
REQ-035 SHALL, on reset during any access, abort that access and issue no vid_valid or cpu_ack for it; a write whose ram_we cycle coincides with reset SHALL be suppressed.

Structure
REQ-036 SHALL place the state enum (IDLE, VID, CPU_RD, CPU_WR) and the default STARVE_MAX constant in the shared pcw_pkg package.
REQ-037 SHALL be a single module with no sub-modules; the request latch and the grant logic stay inline.

Verification
REQ-038 SHALL cover: single vid_req at 17'h00010 with RAM byte 8'hA5 -> vid_valid exactly 2 cycles later with vid_data = 8'hA5.
REQ-039 SHALL cover: CPU write of 8'h3C to 17'h1F000, then CPU read of the same address -> ram_we high for 1 cycle, then cpu_ack with cpu_rdata = 8'h3C.
REQ-040 SHALL cover: cpu_req held high while vid_req strobes every cycle -> the CPU is granted after at most 3 video grants, and cpu_wait is high throughout until cpu_ack.
REQ-041 SHALL cover: vid_req and cpu_req asserted in the same cycle from idle -> video is granted first and the CPU next, with vid_valid then cpu_ack on consecutive cycles.
REQ-042 SHALL cover: reset asserted in the CPU_WR cycle -> no ram_we pulse, no cpu_ack, and all outputs at their REQ-034 values on the next cycle.
